// File: rtl/crystals_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crystals_pkg
// Purpose  : Shared types and constants for the CRYSTALS coefficient datapath.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef Q
`define Q 3329
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

package crystals_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } unpack_state_t;

    localparam int KYBER_COEF_BITS = 12;
    localparam int KYBER_N_PAIRS   = 128;

endpackage
`default_nettype wire

// File: rtl/cond_sub_q.sv
`default_nettype none
// ============================================================================
// Module   : cond_sub_q
// Purpose  : Conditional single subtraction of Q with out-of-range flag.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef Q
`define Q 3329
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module cond_sub_q
    import crystals_pkg::*;
#(
    parameter int COEF_BITS = KYBER_COEF_BITS
) (
    input  logic [COEF_BITS-1:0]  i_v,
    output logic [`DATA_WIDTH:0]  o_r,
    output logic                  o_ovf
);

    localparam int              C_OW = `DATA_WIDTH + 1;
    localparam logic [C_OW-1:0] C_Q  = C_OW'(`Q);

    logic [C_OW-1:0] w_ext;

    // 2^COEF_BITS < 2Q, so one subtraction always lands in 0..Q-1
    assign w_ext = C_OW'(i_v);
    assign o_ovf = (w_ext >= C_Q);
    assign o_r   = o_ovf ? (w_ext - C_Q) : w_ext;

endmodule
`default_nettype wire

// File: rtl/poly_unpack.sv
`default_nettype none
// ============================================================================
// Module   : poly_unpack
// Purpose  : Streaming ByteDecode - packed LSB-first bytes to reduced pairs.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef Q
`define Q 3329
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module poly_unpack
    import crystals_pkg::*;
#(
    parameter int COEF_BITS = KYBER_COEF_BITS,
    parameter int N_PAIRS   = KYBER_N_PAIRS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_byte,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [`DATA_WIDTH:0]  out_coef [2],
    output logic                  out_last,
    output logic                  range_err,
    output logic                  busy,
    output logic                  done
);

    localparam int                C_PAIR_BITS = 2 * COEF_BITS;
    localparam int                C_ACC_W     = C_PAIR_BITS + 8;
    localparam int                C_FILL_W    = $clog2(C_ACC_W + 1);
    localparam int                C_CNT_W     = $clog2(N_PAIRS + 1);
    localparam logic [C_FILL_W-1:0] C_PAIR_FILL = C_FILL_W'(C_PAIR_BITS);
    localparam logic [C_CNT_W-1:0]  C_LAST_IDX  = C_CNT_W'(N_PAIRS - 1);

    unpack_state_t          r_state, w_state_nxt;
    logic [C_ACC_W-1:0]     r_acc, w_acc_base, w_acc_nxt;
    logic [C_FILL_W-1:0]    r_fill, w_fill_base, w_fill_nxt;
    logic [C_CNT_W-1:0]     r_count;
    logic                   r_out_valid, r_out_last, r_range_err, r_done;
    logic [`DATA_WIDTH:0]   r_coef [2];
    logic [`DATA_WIDTH:0]   w_lane [2];
    logic [1:0]             w_ovf;
    logic                   w_extract, w_accept, w_out_fire, w_last_pair;

    assign w_extract   = (r_state == RUN) && (r_fill >= C_PAIR_FILL) &&
                         (!r_out_valid || out_ready);
    assign in_ready    = (r_state == RUN) && ((r_fill < C_PAIR_FILL) || w_extract);
    assign w_accept    = in_valid && in_ready;
    assign w_out_fire  = r_out_valid && out_ready;
    assign w_last_pair = (r_count == C_LAST_IDX);

    assign busy        = (r_state != IDLE);
    assign out_valid   = r_out_valid;
    assign out_last    = r_out_last;
    assign range_err   = r_range_err;
    assign done        = r_done;
    assign out_coef[0] = r_coef[0];
    assign out_coef[1] = r_coef[1];

    for (genvar i = 0; i < 2; i++) begin : g_lane
        cond_sub_q #(
            .COEF_BITS (COEF_BITS)
        ) u_sub (
            .i_v   (r_acc[i*COEF_BITS +: COEF_BITS]),
            .o_r   (w_lane[i]),
            .o_ovf (w_ovf[i])
        );
    end

    // A byte accepted alongside an extract lands just above the bits left over
    always_comb begin
        w_acc_base  = r_acc;
        w_fill_base = r_fill;
        if (w_extract) begin
            w_acc_base  = r_acc >> C_PAIR_BITS;
            w_fill_base = r_fill - C_PAIR_FILL;
        end
        w_acc_nxt  = w_acc_base;
        w_fill_nxt = w_fill_base;
        if (w_accept) begin
            w_acc_nxt  = w_acc_base | (C_ACC_W'(in_byte) << w_fill_base);
            w_fill_nxt = w_fill_base + C_FILL_W'(8);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = IDLE;
                RUN:     if (w_extract && w_last_pair) w_state_nxt = DRAIN;
                DRAIN:   if (w_out_fire) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_fill      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_range_err <= 1'b0;
            r_done      <= 1'b0;
            r_coef[0]   <= '0;
            r_coef[1]   <= '0;
        end else if (start) begin
            r_acc       <= '0;
            r_fill      <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_range_err <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_acc  <= w_acc_nxt;
            r_fill <= w_fill_nxt;
            r_done <= (r_state == DRAIN) && w_out_fire;
            if (w_extract) begin
                r_count     <= r_count + 1'b1;
                r_out_valid <= 1'b1;
                r_out_last  <= w_last_pair;
                r_coef[0]   <= w_lane[0];
                r_coef[1]   <= w_lane[1];
                r_range_err <= r_range_err | (|w_ovf);
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_poly_unpack.sv
`default_nettype none
// ============================================================================
// Module   : tb_poly_unpack
// Purpose  : Self-checking bench for poly_unpack against a bit-level ByteDecode model.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef Q
`define Q 3329
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif

module tb_poly_unpack;
    import crystals_pkg::*;

    localparam int CB     = KYBER_COEF_BITS;
    localparam int NP     = KYBER_N_PAIRS;
    localparam int QV     = `Q;
    localparam int NBYTES = NP * 2 * CB / 8;

    logic                 clk = 1'b0;
    logic                 rst, start, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]           in_byte;
    logic [`DATA_WIDTH:0] out_coef [2];
    logic                 out_last, range_err, busy, done;

    poly_unpack dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_byte   (in_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_coef  (out_coef),
        .out_last  (out_last),
        .range_err (range_err),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] tx[$];
    logic [7:0] stage[$];
    int         e0[$];
    int         e1[$];
    int         rx_idx = 0;
    bit         exp_err = 0;
    bit         feed_en = 0;
    bit         chk_ready_run = 0;
    int         ready_stalls = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference ByteDecode: coefficient bit k of the stream is bit k%8 of byte k/8
    task automatic commit_stage();
        int npairs;
        int v;
        int idx;
        npairs = stage.size() * 8 / (2 * CB);
        for (int p = 0; p < npairs; p++) begin
            for (int lane = 0; lane < 2; lane++) begin
                v = 0;
                for (int b = 0; b < CB; b++) begin
                    idx = p * 2 * CB + lane * CB + b;
                    v |= ((int'(stage[idx / 8]) >> (idx % 8)) & 1) << b;
                end
                if (v >= QV) begin
                    exp_err = 1'b1;
                    v -= QV;
                end
                if (lane == 0) e0.push_back(v);
                else           e1.push_back(v);
            end
        end
        foreach (stage[i]) tx.push_back(stage[i]);
        stage.delete();
    endtask

    task automatic step();
        bit          held;
        logic [31:0] h0, h1;
        logic        hl;
        in_valid = feed_en && (tx.size() > 0);
        in_byte  = (tx.size() > 0) ? tx[0] : 8'h00;
        @(negedge clk);
        held = out_valid && !out_ready && !start && !rst;
        h0   = 32'(out_coef[0]);
        h1   = 32'(out_coef[1]);
        hl   = out_last;
        if (chk_ready_run && in_valid && !in_ready) ready_stalls++;
        if (in_valid && in_ready) void'(tx.pop_front());
        if (out_valid && out_ready && !start) begin
            if (e0.size() == 0) begin
                check("extra_pair", 32'(e0.size()), 32'(1));
            end else begin
                check("lane0", 32'(out_coef[0]), 32'(e0.pop_front()));
                check("lane1", 32'(out_coef[1]), 32'(e1.pop_front()));
                check("out_last", 32'(out_last), 32'(rx_idx == NP - 1));
            end
            rx_idx++;
        end
        @(posedge clk);
        #1;
        if (held && !rst) begin
            check("hold_valid", 32'(out_valid), 32'(1));
            check("hold_lane0", 32'(out_coef[0]), h0);
            check("hold_lane1", 32'(out_coef[1]), h1);
            check("hold_last", 32'(out_last), 32'(hl));
        end
    endtask

    task automatic pulse_start();
        bit fe;
        fe = feed_en;
        feed_en = 1'b0;
        e0.delete();
        e1.delete();
        tx.delete();
        rx_idx  = 0;
        exp_err = 1'b0;
        start   = 1'b1;
        step();
        start   = 1'b0;
        feed_en = fe;
    endtask

    task automatic stage_random(input int n);
        for (int i = 0; i < n; i++) stage.push_back(8'($urandom));
    endtask

    initial begin
        int c_empty;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_coef0", 32'(out_coef[0]), 32'(0));
        check("rst_coef1", 32'(out_coef[1]), 32'(0));
        check("rst_out_last", 32'(out_last), 32'(0));
        check("rst_range_err", 32'(range_err), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        rst = 1'b0;
        step();

        // Single pair with fixed bytes
        pulse_start();
        check("start_busy", 32'(busy), 32'(1));
        check("start_in_ready", 32'(in_ready), 32'(1));
        stage = '{8'h01, 8'h23, 8'h45};
        commit_stage();
        feed_en = 1'b1; out_ready = 1'b1;
        repeat (3) step();
        check("single_bytes_taken", 32'(tx.size()), 32'(0));
        check("single_latency_lo", 32'(out_valid), 32'(0));
        step();
        check("single_valid", 32'(out_valid), 32'(1));
        check("single_coef0", 32'(out_coef[0]), 32'h301);
        check("single_coef1", 32'(out_coef[1]), 32'h452);
        check("single_range", 32'(range_err), 32'(0));
        step();
        check("single_rx", 32'(rx_idx), 32'(1));

        // Out-of-range reduction and sticky flag
        pulse_start();
        stage = '{8'hFF, 8'hFF, 8'hFF};
        commit_stage();
        repeat (4) step();
        check("range_valid", 32'(out_valid), 32'(1));
        check("range_coef0", 32'(out_coef[0]), 32'(766));
        check("range_coef1", 32'(out_coef[1]), 32'(766));
        check("range_err_set", 32'(range_err), 32'(1));
        repeat (4) step();
        check("range_err_sticky", 32'(range_err), 32'(1));
        pulse_start();
        check("range_err_cleared", 32'(range_err), 32'(0));

        // Full polynomial, back-to-back, no backpressure
        stage_random(NBYTES);
        commit_stage();
        chk_ready_run = 1'b1; ready_stalls = 0; c_empty = -1;
        for (int c = 0; c < 3000 && rx_idx < NP; c++) begin
            step();
            if (c_empty < 0 && tx.size() == 0) c_empty = c + 1;
        end
        chk_ready_run = 1'b0;
        check("full_pairs", 32'(rx_idx), 32'(NP));
        check("full_left", 32'(e0.size()), 32'(0));
        check("full_byte_cycles", 32'(c_empty), 32'(NBYTES));
        check("full_ready_stalls", 32'(ready_stalls), 32'(0));
        check("full_done", 32'(done), 32'(1));
        check("full_busy_fall", 32'(busy), 32'(0));
        check("full_range", 32'(range_err), 32'(exp_err));
        step();
        check("full_done_pulse", 32'(done), 32'(0));
        check("idle_in_ready", 32'(in_ready), 32'(0));

        // Backpressure: stall after first pair, then random out_ready
        pulse_start();
        stage_random(NBYTES);
        commit_stage();
        out_ready = 1'b1;
        for (int c = 0; c < 50 && rx_idx < 1; c++) step();
        check("bp_first", 32'(rx_idx), 32'(1));
        out_ready = 1'b0;
        repeat (10) step();
        check("bp_in_ready_low", 32'(in_ready), 32'(0));
        check("bp_held_valid", 32'(out_valid), 32'(1));
        check("bp_no_pairs", 32'(rx_idx), 32'(1));
        for (int c = 0; c < 5000 && rx_idx < NP; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        out_ready = 1'b1;
        check("bp_pairs", 32'(rx_idx), 32'(NP));
        check("bp_left", 32'(e0.size()), 32'(0));
        for (int c = 0; c < 5 && busy; c++) step();
        check("bp_idle", 32'(busy), 32'(0));

        // Abort after 100 bytes, then a full polynomial
        pulse_start();
        stage_random(100);
        commit_stage();
        for (int c = 0; c < 300 && tx.size() > 0; c++) step();
        check("abort_fed", 32'(tx.size()), 32'(0));
        out_ready = 1'b0;
        repeat (2) step();
        pulse_start();
        check("abort_valid", 32'(out_valid), 32'(0));
        check("abort_busy", 32'(busy), 32'(1));
        out_ready = 1'b1;
        stage_random(NBYTES);
        commit_stage();
        for (int c = 0; c < 3000 && rx_idx < NP; c++) step();
        check("abort_pairs", 32'(rx_idx), 32'(NP));
        check("abort_done", 32'(done), 32'(1));

        // Asynchronous reset mid-stream with a pair pending
        pulse_start();
        stage_random(NBYTES);
        commit_stage();
        out_ready = 1'b0;
        for (int c = 0; c < 20 && !out_valid; c++) step();
        check("rst_pre_valid", 32'(out_valid), 32'(1));
        #3;
        rst = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'(0));
        check("arst_out_valid", 32'(out_valid), 32'(0));
        check("arst_coef0", 32'(out_coef[0]), 32'(0));
        check("arst_coef1", 32'(out_coef[1]), 32'(0));
        check("arst_out_last", 32'(out_last), 32'(0));
        check("arst_range_err", 32'(range_err), 32'(0));
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_done", 32'(done), 32'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulse_start();
        stage_random(3);
        commit_stage();
        out_ready = 1'b1;
        for (int c = 0; c < 20 && rx_idx < 1; c++) step();
        check("post_rst_pair", 32'(rx_idx), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
